brownout_ctrl: RTL and testbench

BROWNOUT_CTRL -- requirements
Module: brownout_ctrl

---
 rtl/brownout_pkg.sv | 29 ++
 rtl/brownout_sync.sv | 24 ++
 rtl/brownout_ctrl.sv | 158 +++++++++++++++
 tb/tb_brownout_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/brownout_pkg.sv
// Shared definitions for the brownout controller: FSM states, default timing
// and helpers for sizing its counters.
package brownout_pkg;

  typedef enum logic [1:0] {
    OFF         = 2'd0,
    BIAS_SETTLE = 2'd1,
    COMP_SETTLE = 2'd2,
    ACTIVE      = 2'd3
  } bo_state_t;

  localparam int DEF_SETTLE_CYC = 16;
  localparam int DEF_COMP_CYC   = 8;
  localparam int DEF_DBNC_CYC   = 8;

  localparam int              BO_CNT_W   = 8;
  localparam logic [BO_CNT_W-1:0] BO_CNT_MAX = 8'hFF;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold values 0..n; never narrower than one bit.
  function automatic int cnt_width(input int n);
    if (n < 1) return 1;
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/brownout_sync.sv
// Two-flop synchronizer bringing the raw comparator output into the clk domain.
module brownout_sync (
  input  logic clk,
  input  logic rstn,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/brownout_ctrl.sv
// Brownout detector sequencer: powers up bias then comparator, debounces the
// comparator output into vunder and counts brownout events.
module brownout_ctrl
  import brownout_pkg::*;
#(
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int COMP_CYC   = DEF_COMP_CYC,
  parameter int DBNC_CYC   = DEF_DBNC_CYC
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                ena,
  input  logic                isrc_sel,
  input  logic [2:0]          otrip,
  input  logic                vtrip_comp,
  input  logic                cnt_clr,
  output logic                ibias_ena,
  output logic                isrc_sel_o,
  output logic [2:0]          otrip_o,
  output logic                comp_ena,
  output logic                ready,
  output logic                vunder,
  output logic [BO_CNT_W-1:0] bo_cnt
);

  localparam int SET_W = cnt_width(max2(SETTLE_CYC, COMP_CYC));
  localparam int DB_W  = cnt_width(DBNC_CYC);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [SET_W-1:0] COMP_LAST   = SET_W'(COMP_CYC - 1);
  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DBNC_CYC - 1);

  bo_state_t             r_state, w_state_next;
  logic [SET_W-1:0]      r_settle_cnt, w_settle_next;
  logic [DB_W-1:0]       r_dbnc_cnt, w_dbnc_next;
  logic                  r_vunder, w_vunder_next;
  logic [BO_CNT_W-1:0]   r_bo_cnt, w_bo_next;
  logic                  r_ibias_ena, r_comp_ena, r_ready;
  logic                  r_isrc_sel;
  logic [2:0]            r_otrip;
  logic                  w_comp_sync;
  logic                  w_rise;
  logic                  w_capture;

  brownout_sync u_sync (
    .clk  (clk),
    .rstn (rstn),
    .i_d  (vtrip_comp),
    .o_q  (w_comp_sync)
  );

  always_comb begin
    w_state_next  = r_state;
    w_settle_next = r_settle_cnt;
    if (!ena) begin
      w_state_next  = OFF;
      w_settle_next = '0;
    end else begin
      case (r_state)
        OFF: begin
          w_state_next  = BIAS_SETTLE;
          w_settle_next = '0;
        end
        BIAS_SETTLE: begin
          if (r_settle_cnt == SETTLE_LAST) begin
            w_state_next  = COMP_SETTLE;
            w_settle_next = '0;
          end else begin
            w_settle_next = r_settle_cnt + SET_W'(1);
          end
        end
        COMP_SETTLE: begin
          if (r_settle_cnt == COMP_LAST) begin
            w_state_next  = ACTIVE;
            w_settle_next = '0;
          end else begin
            w_settle_next = r_settle_cnt + SET_W'(1);
          end
        end
        ACTIVE:  w_settle_next = '0;
        default: w_state_next  = OFF;
      endcase
    end
  end

  assign w_capture = ena && (r_state == OFF);

  // A sample equal to the current flag restarts the run; a full run flips it.
  always_comb begin
    w_dbnc_next   = r_dbnc_cnt;
    w_vunder_next = r_vunder;
    w_rise        = 1'b0;
    if (!ena) begin
      w_dbnc_next   = '0;
      w_vunder_next = 1'b0;
    end else if (r_state == ACTIVE) begin
      if (w_comp_sync != r_vunder) begin
        if (r_dbnc_cnt == DB_LAST) begin
          w_dbnc_next   = '0;
          w_vunder_next = w_comp_sync;
          w_rise        = w_comp_sync;
        end else begin
          w_dbnc_next = r_dbnc_cnt + DB_W'(1);
        end
      end else begin
        w_dbnc_next = '0;
      end
    end else begin
      w_dbnc_next = '0;
    end
  end

  // Clear wins over increment, but a rise on the same edge still counts once.
  always_comb begin
    w_bo_next = r_bo_cnt;
    if (cnt_clr) begin
      w_bo_next = {{(BO_CNT_W-1){1'b0}}, w_rise};
    end else if (w_rise && (r_bo_cnt != BO_CNT_MAX)) begin
      w_bo_next = r_bo_cnt + BO_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= OFF;
      r_settle_cnt <= '0;
      r_dbnc_cnt   <= '0;
      r_vunder     <= 1'b0;
      r_bo_cnt     <= '0;
      r_ibias_ena  <= 1'b0;
      r_comp_ena   <= 1'b0;
      r_ready      <= 1'b0;
      r_isrc_sel   <= 1'b0;
      r_otrip      <= '0;
    end else begin
      r_state      <= w_state_next;
      r_settle_cnt <= w_settle_next;
      r_dbnc_cnt   <= w_dbnc_next;
      r_vunder     <= w_vunder_next;
      r_bo_cnt     <= w_bo_next;
      r_ibias_ena  <= (w_state_next != OFF);
      r_comp_ena   <= (w_state_next == COMP_SETTLE) || (w_state_next == ACTIVE);
      r_ready      <= (w_state_next == ACTIVE);
      if (w_capture) begin
        r_isrc_sel <= isrc_sel;
        r_otrip    <= otrip;
      end
    end
  end

  assign ibias_ena  = r_ibias_ena;
  assign comp_ena   = r_comp_ena;
  assign ready      = r_ready;
  assign isrc_sel_o = r_isrc_sel;
  assign otrip_o    = r_otrip;
  assign vunder     = r_vunder;
  assign bo_cnt     = r_bo_cnt;

endmodule

// File: tb/tb_brownout_ctrl.sv
// Directed bench for brownout_ctrl: a time-since-enable / sample-window model
// checked every cycle, plus literal expectations at the key edges.
module tb_brownout_ctrl;

  localparam int SETTLE = 16;
  localparam int COMP   = 8;
  localparam int DBNC   = 8;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       ena = 1'b0;
  logic       isrc_sel = 1'b0;
  logic [2:0] otrip = 3'd0;
  logic       vtrip_comp = 1'b0;
  logic       cnt_clr = 1'b0;
  logic       ibias_ena, isrc_sel_o, comp_ena, ready, vunder;
  logic [2:0] otrip_o;
  logic [7:0] bo_cnt;

  always #5 clk = ~clk;

  brownout_ctrl #(
    .SETTLE_CYC (SETTLE),
    .COMP_CYC   (COMP),
    .DBNC_CYC   (DBNC)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .ena        (ena),
    .isrc_sel   (isrc_sel),
    .otrip      (otrip),
    .vtrip_comp (vtrip_comp),
    .cnt_clr    (cnt_clr),
    .ibias_ena  (ibias_ena),
    .isrc_sel_o (isrc_sel_o),
    .otrip_o    (otrip_o),
    .comp_ena   (comp_ena),
    .ready      (ready),
    .vunder     (vunder),
    .bo_cnt     (bo_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_age = edges since the enabling edge; enables follow from it directly.
  int         m_age = 0;
  logic       m_isrc = 1'b0;
  logic [2:0] m_otrip = 3'd0;
  logic       m_vunder = 1'b0;
  int         m_bo = 0;
  logic       m_h1 = 1'b0, m_h2 = 1'b0;
  logic       m_win[$];

  always @(posedge clk or negedge rstn) begin : model
    logic was_active, rise, samp;
    if (!rstn) begin
      m_age = 0; m_isrc = 1'b0; m_otrip = 3'd0; m_vunder = 1'b0;
      m_bo = 0; m_h1 = 1'b0; m_h2 = 1'b0; m_win.delete();
    end else begin
      was_active = (m_age > SETTLE + COMP);
      samp = m_h2;
      rise = 1'b0;
      if (!ena) begin
        m_age = 0; m_vunder = 1'b0; m_win.delete();
      end else begin
        if (m_age == 0) begin
          m_isrc = isrc_sel;
          m_otrip = otrip;
        end
        if (m_age < 1000) m_age++;
        if (was_active && (samp !== m_vunder)) begin
          m_win.push_back(samp);
          if (m_win.size() == DBNC) begin
            m_vunder = samp;
            rise = samp;
            m_win.delete();
          end
        end else begin
          m_win.delete();
        end
      end
      if (cnt_clr) m_bo = rise ? 1 : 0;
      else if (rise && m_bo < 255) m_bo++;
      m_h2 = m_h1;
      m_h1 = vtrip_comp;
    end
  end

  always @(negedge clk) begin
    check("ibias_ena", ibias_ena, m_age >= 1);
    check("comp_ena", comp_ena, m_age >= SETTLE + 1);
    check("ready", ready, m_age >= SETTLE + COMP + 1);
    check("isrc_sel_o", isrc_sel_o, m_isrc);
    check("otrip_o", otrip_o, m_otrip);
    check("vunder", vunder, m_vunder);
    check("bo_cnt", bo_cnt, m_bo);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    step(3);
    check("rst_ibias", ibias_ena, 0);
    check("rst_bo", bo_cnt, 0);
    check("rst_otrip", otrip_o, 0);

    // Bring-up: the first rising edge after this is edge 1.
    rstn = 1'b1; ena = 1'b1; isrc_sel = 1'b1; otrip = 3'd5;
    step(1);
    check("e1_ibias", ibias_ena, 1);
    check("e1_comp", comp_ena, 0);
    otrip = 3'd2; isrc_sel = 1'b0;
    step(15);
    check("e16_comp", comp_ena, 0);
    step(1);
    check("e17_comp", comp_ena, 1);
    step(7);
    check("e24_ready", ready, 0);
    step(1);
    check("e25_ready", ready, 1);
    check("e25_isrc_o", isrc_sel_o, 1);
    check("e25_otrip_o", otrip_o, 5);

    vtrip_comp = 1'b1;
    step(9);
    check("rise9_vunder", vunder, 0);
    step(1);
    check("rise10_vunder", vunder, 1);
    check("rise10_bo", bo_cnt, 1);
    vtrip_comp = 1'b0;
    step(9);
    check("fall9_vunder", vunder, 1);
    step(1);
    check("fall10_vunder", vunder, 0);

    vtrip_comp = 1'b1;
    step(7);
    vtrip_comp = 1'b0;
    step(12);
    check("glitch_vunder", vunder, 0);
    check("glitch_bo", bo_cnt, 1);

    for (int i = 0; i < 259; i++) begin
      vtrip_comp = 1'b1;
      step(10);
      vtrip_comp = 1'b0;
      step(10);
    end
    check("sat_bo", bo_cnt, 255);

    vtrip_comp = 1'b1;
    step(9);
    cnt_clr = 1'b1;
    step(1);
    cnt_clr = 1'b0;
    check("clr_rise_bo", bo_cnt, 1);
    check("clr_rise_vunder", vunder, 1);

    // Asynchronous reset between clock edges.
    #2 rstn = 1'b0;
    #1;
    check("arst_ibias", ibias_ena, 0);
    check("arst_comp", comp_ena, 0);
    check("arst_ready", ready, 0);
    check("arst_vunder", vunder, 0);
    check("arst_bo", bo_cnt, 0);
    check("arst_otrip", otrip_o, 0);
    check("arst_isrc", isrc_sel_o, 0);
    vtrip_comp = 1'b0;
    step(2);

    rstn = 1'b1; isrc_sel = 1'b1; otrip = 3'd3;
    step(20);
    check("cs_comp", comp_ena, 1);
    ena = 1'b0;
    step(1);
    check("drop_ibias", ibias_ena, 0);
    check("drop_comp", comp_ena, 0);
    check("drop_ready", ready, 0);
    check("drop_otrip_hold", otrip_o, 3);
    ena = 1'b1; isrc_sel = 1'b0; otrip = 3'd6;
    step(1);
    check("re_ibias", ibias_ena, 1);
    check("re_isrc_o", isrc_sel_o, 0);
    check("re_otrip_o", otrip_o, 6);
    otrip = 3'd1;
    step(15);
    check("re16_comp", comp_ena, 0);
    step(1);
    check("re17_comp", comp_ena, 1);
    step(7);
    check("re24_ready", ready, 0);
    step(1);
    check("re25_ready", ready, 1);
    check("re25_otrip_o", otrip_o, 6);

    vtrip_comp = 1'b1;
    step(10);
    check("ev_vunder", vunder, 1);
    ena = 1'b0;
    step(1);
    check("off_vunder", vunder, 0);
    check("off_bo_hold", bo_cnt, 1);
    ena = 1'b1; cnt_clr = 1'b1;
    step(1);
    cnt_clr = 1'b0;
    check("clr_bo", bo_cnt, 0);
    step(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
